// File: rtl/pattern_scheduler_if.sv
// Handshake bundle between the pattern scheduler and its surroundings:
// board pins and divider strobe in, pattern select, frame index and blanking out.
interface pattern_scheduler_if;
    logic       i_tick;
    logic       i_auto;
    logic [1:0] i_sel;
    logic       i_next;
    logic [1:0] o_sel;
    logic [2:0] o_count;
    logic       o_blank;
    logic       o_loop_done;

    modport master (
        output i_tick, i_auto, i_sel, i_next,
        input  o_sel, o_count, o_blank, o_loop_done
    );

    modport slave (
        input  i_tick, i_auto, i_sel, i_next,
        output o_sel, o_count, o_blank, o_loop_done
    );
endinterface

// File: rtl/pattern_scheduler.sv
// Sequencing controller for the seven-segment pattern datapath: frame index with
// per-pattern loop length, manual/auto pattern selection and change blanking.
module pattern_scheduler #(
    parameter int unsigned DWELL_LOOPS = 2,
    parameter int unsigned BLANK_TICKS = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    pattern_scheduler_if.slave  bus
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_BLANK = 1'b1;
    localparam logic [3:0] DWELL_C  = 4'(DWELL_LOOPS);
    localparam logic [2:0] BLANK_C  = 3'(BLANK_TICKS);

    // Last frame index of each pattern: rand and cw8 run 8 frames, scan 4, warning 2.
    function automatic logic [2:0] loop_last(input logic [1:0] sel);
        logic [2:0] last;
        case (sel)
            2'd0:    last = 3'd7;
            2'd1:    last = 3'd7;
            2'd2:    last = 3'd3;
            2'd3:    last = 3'd1;
            default: last = 3'd7;
        endcase
        return last;
    endfunction

    logic       auto_s1_q, auto_s1_d, auto_s2_q, auto_s2_d;
    logic [1:0] sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
    logic       next_s1_q, next_s1_d, next_s2_q, next_s2_d;
    logic       next_hist_q, next_hist_d;
    logic [0:0] state_q, state_d;
    logic       mode_q, mode_d;
    logic [1:0] sel_q, sel_d;
    logic [2:0] count_q, count_d;
    logic [3:0] loop_q, loop_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic       blank_q, blank_d;
    logic       loop_done_q, loop_done_d;

    logic       next_rise_s;
    logic       wrap_s;
    logic [3:0] loop_inc_s;

    // Next-state computation for synchronisers, sequencer FSM and registered outputs.
    always_comb begin
        auto_s1_d   = bus.i_auto;
        auto_s2_d   = auto_s1_q;
        sel_s1_d    = bus.i_sel;
        sel_s2_d    = sel_s1_q;
        next_s1_d   = bus.i_next;
        next_s2_d   = next_s1_q;
        next_hist_d = next_s2_q;

        next_rise_s = next_s2_q & ~next_hist_q;
        wrap_s      = bus.i_tick & (count_q == loop_last(sel_q));
        loop_inc_s  = wrap_s ? (loop_q + 4'd1) : loop_q;

        state_d     = state_q;
        mode_d      = mode_q;
        sel_d       = sel_q;
        count_d     = count_q;
        loop_d      = loop_q;
        bcnt_d      = bcnt_q;
        loop_done_d = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (wrap_s) begin
                    count_d = 3'd0;
                end else if (bus.i_tick) begin
                    count_d = count_q + 3'd1;
                end else begin
                    count_d = count_q;
                end
                loop_done_d = wrap_s;
                mode_d      = auto_s2_q;

                if (auto_s2_q) begin
                    // First RUN cycle after entering auto restarts the dwell from zero.
                    if (!mode_q) begin
                        loop_d = 4'd0;
                    end else if (next_rise_s || (loop_inc_s == DWELL_C)) begin
                        sel_d   = sel_q + 2'd1;
                        count_d = 3'd0;
                        loop_d  = 4'd0;
                        bcnt_d  = 3'd0;
                        state_d = ST_BLANK;
                    end else begin
                        loop_d = loop_inc_s;
                    end
                end else begin
                    if (sel_s2_q != sel_q) begin
                        sel_d   = sel_s2_q;
                        count_d = 3'd0;
                        loop_d  = 4'd0;
                        bcnt_d  = 3'd0;
                        state_d = ST_BLANK;
                    end else if (wrap_s && (loop_q < DWELL_C)) begin
                        loop_d = loop_q + 4'd1;
                    end else begin
                        loop_d = loop_q;
                    end
                end
            end

            ST_BLANK: begin
                count_d = 3'd0;
                if ((BLANK_C == 3'd0) || (bus.i_tick && ((bcnt_q + 3'd1) == BLANK_C))) begin
                    bcnt_d  = 3'd0;
                    state_d = ST_RUN;
                end else if (bus.i_tick) begin
                    bcnt_d = bcnt_q + 3'd1;
                end else begin
                    bcnt_d = bcnt_q;
                end
            end

            default: begin
                state_d = ST_RUN;
                count_d = 3'd0;
                bcnt_d  = 3'd0;
            end
        endcase

        blank_d = (state_d == ST_BLANK);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            auto_s1_q   <= 1'b0;
            auto_s2_q   <= 1'b0;
            sel_s1_q    <= 2'd0;
            sel_s2_q    <= 2'd0;
            next_s1_q   <= 1'b0;
            next_s2_q   <= 1'b0;
            next_hist_q <= 1'b0;
            state_q     <= ST_RUN;
            mode_q      <= 1'b0;
            sel_q       <= 2'd0;
            count_q     <= 3'd0;
            loop_q      <= 4'd0;
            bcnt_q      <= 3'd0;
            blank_q     <= 1'b0;
            loop_done_q <= 1'b0;
        end else begin
            auto_s1_q   <= auto_s1_d;
            auto_s2_q   <= auto_s2_d;
            sel_s1_q    <= sel_s1_d;
            sel_s2_q    <= sel_s2_d;
            next_s1_q   <= next_s1_d;
            next_s2_q   <= next_s2_d;
            next_hist_q <= next_hist_d;
            state_q     <= state_d;
            mode_q      <= mode_d;
            sel_q       <= sel_d;
            count_q     <= count_d;
            loop_q      <= loop_d;
            bcnt_q      <= bcnt_d;
            blank_q     <= blank_d;
            loop_done_q <= loop_done_d;
        end
    end

    assign bus.o_sel       = sel_q;
    assign bus.o_count     = count_q;
    assign bus.o_blank     = blank_q;
    assign bus.o_loop_done = loop_done_q;

endmodule

// File: doc/pattern_scheduler.md
Name: pattern_scheduler

Overview:
- Sequencing controller for the seven-segment pattern display datapath: the four pattern generators, the mod-8 frame counter and the 4:1 pattern mux.
- Replaces the free-running frame counter and the raw pin select.
- Generates the frame index with a per-pattern loop length.
- Selects the active pattern, either from pins (manual) or by auto-rotation after a dwell period or a skip button.
- Drives a blanking strobe for the segment outputs during pattern changes.
- Clocked on the board clock, advancing on the divided-clock strobe.

Parameters:
DWELL_LOOPS, 2, complete loops of the active pattern before auto-advance; legal range 1..15
BLANK_TICKS, 1, ticks of blanking after each pattern change; legal range 0..7

Ports:
i_clk  input  1  board clock; all state updates on rising edge
i_rst  input  1  synchronous reset, active-high
i_tick  input  1  one-i_clk-cycle enable strobe from the clock divider (2 Hz)
i_auto  input  1  pin: 1 = auto-rotate mode, 0 = manual mode
i_sel  input  2  pin: manual pattern select (0 rand, 1 cw8, 2 scan, 3 warning)
i_next  input  1  pin: skip button, level, active-high
o_sel  output  2  pattern select to mux
o_count  output  3  frame index to pattern generators
o_blank  output  1  1 = segments forced off by top level
o_loop_done  output  1  one-cycle pulse at pattern loop wrap

Behaviour:
- Reset, synchronous: all registers clear; nothing else is clocked while i_rst = 1.
  - o_sel = 0, o_count = 0, o_blank = 0, o_loop_done = 0.
  - State = RUN, loop counter = 0, blank counter = 0.
  - Synchroniser flops = 0, edge-detect history = 0.
- Input synchronisation:
  - i_auto, i_sel and i_next each pass through a 2-flop synchroniser.
  - The FSM acts on the synchronised values, so a pin change affects outputs on the 3rd rising edge after it.
  - i_next has rising-edge detection on its synchronised value.
  - A button held through reset produces one edge after reset.
  - i_tick is already synchronous and is not synchronised.
- Loop length L(o_sel): sel 0 → 8, sel 1 → 8, sel 2 → 4, sel 3 → 2.
  - o_count never exceeds L-1.
- State RUN (o_blank = 0), on i_tick:
  - If o_count = L-1: o_count ← 0, o_loop_done = 1 for that cycle, loop counter +1.
  - Otherwise o_count +1.
- Auto mode (synced i_auto = 1):
  - Advance when the loop counter reaches DWELL_LOOPS, or on an i_next rising edge.
  - Advance does: o_sel ← o_sel+1 mod 4, o_count ← 0, loop counter ← 0, go to BLANK.
  - 3 wraps to 0.
- Manual mode (synced i_auto = 0):
  - If synced i_sel ≠ o_sel: o_sel ← synced i_sel, o_count ← 0, loop counter ← 0, go to BLANK.
  - i_next ignored; loop counter saturates at DWELL_LOOPS.
- State BLANK:
  - o_blank = 1 and o_count held at 0.
  - The blank counter counts i_tick; return to RUN on the clock where it reaches BLANK_TICKS.
  - If BLANK_TICKS = 0, BLANK lasts exactly one i_clk cycle.
  - o_loop_done is never asserted in BLANK.
  - i_next edges in BLANK are dropped.
  - Manual select changes in BLANK are evaluated on return to RUN.
- Mode switch: takes effect in RUN on the next cycle.
  - Auto→manual with synced i_sel = o_sel: no blank, count continues.
  - Auto→manual with synced i_sel ≠ o_sel: normal manual change.
  - Manual→auto: loop counter ← 0, o_sel kept, count continues.
- Simultaneous events:
  - Tick-wrap coinciding with dwell completion or an i_next edge: o_loop_done still pulses, and o_sel advances by exactly 1.
  - Tick coinciding with a manual select change: the change wins; o_count = 0.
- Reset mid-BLANK or mid-loop: returns to reset values on the next edge.
- Loop counter: 4 bits. Blank counter: 3 bits.

Test Plan:
- Reset and wrap: i_rst 1 for 2 cycles, then auto = 0, sel = 2, 9 ticks. Required:
  - o_sel = 2 after sync.
  - o_count sequence 0,1,2,3,0,1,2,3,0.
  - o_loop_done pulses on the 4th and 8th ticks.
  - o_blank = 0 throughout.
- Auto dwell: auto = 1, DWELL_LOOPS = 2, BLANK_TICKS = 1, start sel 0. Required:
  - After 16 ticks, o_sel = 1 and o_blank = 1 until the next tick.
  - Then sel 1 for 16 ticks, sel 2 for 8, sel 3 for 4, then back to 0.
- Skip: auto = 1, sel 0, i_next pulse at o_count = 3. Required:
  - 3 clocks later o_sel = 1, o_count = 0, o_blank = 1.
  - A second i_next during BLANK has no effect.
- Manual change latency: i_sel 0 → 3 at cycle t. Required:
  - o_sel = 3 and o_blank = 1 at edge t+3.
  - o_count = 0.
  - After the blank, count runs 0,1,0.
- Coincidence: auto, sel 3, DWELL_LOOPS = 1, i_next edge on the same cycle as the tick wrapping 1 → 0. Required:
  - o_loop_done = 1.
  - o_sel = 0, advanced exactly once.
- Reset in BLANK: assert i_rst while o_blank = 1. Required:
  - Next edge: o_sel = 0, o_count = 0, o_blank = 0, o_loop_done = 0.
